// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared pointer-width helpers and Gray/binary conversions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

   function automatic int ptr_w(input int addr_size);
      return addr_size + 1;
   endfunction

   function automatic int depth(input int addr_size);
      return 1 << addr_size;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits keep the prefix XOR correct for narrower pointers.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/r_ptr_level_mod_if.sv
// ---------------------------------------------------------------------------
// r_ptr_level_mod_if : read-side pointer/status signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface r_ptr_level_mod_if #(
   parameter int ADDR_SIZE = 4
);
   logic [ADDR_SIZE:0]   r_syn_w_gray;
   logic                 r_inc;
   logic                 r_thresh_wr;
   logic [ADDR_SIZE:0]   r_thresh_in;
   logic                 r_err_clr;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [ADDR_SIZE:0]   r_gray;
   logic [ADDR_SIZE:0]   r_level;
   logic                 r_empty;
   logic                 r_almost_empty;
   logic                 r_underflow;
   logic                 r_ptr_err;

   modport master (
      output r_syn_w_gray, r_inc, r_thresh_wr, r_thresh_in, r_err_clr,
      input  r_addr, r_gray, r_level, r_empty, r_almost_empty, r_underflow, r_ptr_err
   );

   modport slave (
      input  r_syn_w_gray, r_inc, r_thresh_wr, r_thresh_in, r_err_clr,
      output r_addr, r_gray, r_level, r_empty, r_almost_empty, r_underflow, r_ptr_err
   );
endinterface

`default_nettype wire

// File: rtl/r_ptr_level_mod_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin_mod : parametrised combinational Gray-to-binary decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray2bin_mod
   import fifo_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  wire logic [WIDTH-1:0] gray,
   output logic      [WIDTH-1:0] bin
);
   logic [31:0] bin_full;

   assign bin_full = gray2bin(32'(gray));
   assign bin      = bin_full[WIDTH-1:0];
endmodule

`default_nettype wire

// File: rtl/r_ptr_level_mod.sv
// ---------------------------------------------------------------------------
// r_ptr_level_mod : read pointer, fill level, empty/almost-empty and errors
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module r_ptr_level_mod
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE       = 4,
   parameter int AE_RESET_THRESH = 4
) (
   input  wire logic        r_clk,
   input  wire logic        r_rst,
   r_ptr_level_mod_if.slave bus
);
   localparam int            PW         = ptr_w(ADDR_SIZE);
   localparam logic [PW-1:0] DEPTH_P    = PW'(depth(ADDR_SIZE));
   localparam logic [PW-1:0] THRESH_RST = (AE_RESET_THRESH > depth(ADDR_SIZE)) ?
                                          DEPTH_P : PW'(AE_RESET_THRESH);

   logic [PW-1:0] w_bin;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] lvl_next;
   logic [PW-1:0] thresh_sat;
   logic [31:0]   gray_full;
   logic          rd_ok;

   logic [PW-1:0] r_bin;
   logic [PW-1:0] r_gray;
   logic [PW-1:0] r_level;
   logic [PW-1:0] r_thresh;
   logic          r_empty;
   logic          r_almost_empty;
   logic          r_underflow;
   logic          r_ptr_err;

   gray2bin_mod #(.WIDTH(PW)) u_w_dec (
      .gray (bus.r_syn_w_gray),
      .bin  (w_bin)
   );

   always_comb begin
      rd_ok      = bus.r_inc & ~r_empty;
      bin_next   = r_bin + PW'(rd_ok);
      gray_full  = bin2gray(32'(bin_next));
      gray_next  = gray_full[PW-1:0];
      // Modulo subtraction absorbs either pointer lapping the MSB first.
      lvl_next   = w_bin - bin_next;
      thresh_sat = (bus.r_thresh_in > DEPTH_P) ? DEPTH_P : bus.r_thresh_in;
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_bin          <= '0;
         r_gray         <= '0;
         r_level        <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_underflow    <= 1'b0;
         r_ptr_err      <= 1'b0;
         r_thresh       <= THRESH_RST;
      end else begin
         r_bin          <= bin_next;
         r_gray         <= gray_next;
         r_level        <= lvl_next;
         r_empty        <= (lvl_next == '0);
         r_almost_empty <= (lvl_next <= r_thresh);
         if (bus.r_thresh_wr) begin
            r_thresh <= thresh_sat;
         end
         // Set takes priority over a same-cycle clear on both sticky flags.
         if (bus.r_inc && r_empty) begin
            r_underflow <= 1'b1;
         end else if (bus.r_err_clr) begin
            r_underflow <= 1'b0;
         end
         if (lvl_next > DEPTH_P) begin
            r_ptr_err <= 1'b1;
         end else if (bus.r_err_clr) begin
            r_ptr_err <= 1'b0;
         end
      end
   end

   assign bus.r_addr         = r_bin[ADDR_SIZE-1:0];
   assign bus.r_gray         = r_gray;
   assign bus.r_level        = r_level;
   assign bus.r_empty        = r_empty;
   assign bus.r_almost_empty = r_almost_empty;
   assign bus.r_underflow    = r_underflow;
   assign bus.r_ptr_err      = r_ptr_err;
endmodule

`default_nettype wire

// File: tb/tb_r_ptr_level_mod.sv
// ---------------------------------------------------------------------------
// tb_r_ptr_level_mod : directed and random checks against a counting model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_r_ptr_level_mod;
   localparam int AS = 4;
   localparam int D  = 16;
   localparam int M  = 32;

   logic r_clk = 1'b0;
   logic r_rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   int m_rbin = 0, m_w = 0, m_level = 0, m_thresh = 4;
   bit m_empty = 1'b1, m_ae = 1'b1, m_uf = 1'b0, m_pe = 1'b0;

   r_ptr_level_mod_if #(.ADDR_SIZE(AS)) bus ();

   r_ptr_level_mod #(.ADDR_SIZE(AS), .AE_RESET_THRESH(4)) dut (
      .r_clk (r_clk),
      .r_rst (r_rst),
      .bus   (bus.slave)
   );

   always #5 r_clk = ~r_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setw(input int w);
      m_w = w % M;
      bus.r_syn_w_gray = 5'(m_w ^ (m_w >> 1));
   endtask

   // Model: fill level is simply writes minus reads, counted modulo 2*depth.
   task automatic step();
      int nr, lv;
      bit rd;
      if (r_rst) begin
         m_rbin = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
         m_uf = 1'b0; m_pe = 1'b0; m_thresh = 4;
      end else begin
         rd = bus.r_inc && !m_empty;
         nr = (m_rbin + int'(rd)) % M;
         lv = (m_w + M - nr) % M;
         m_uf = (bus.r_inc && m_empty) ? 1'b1 : (bus.r_err_clr ? 1'b0 : m_uf);
         m_pe = (lv > D) ? 1'b1 : (bus.r_err_clr ? 1'b0 : m_pe);
         m_empty = (lv == 0);
         m_ae = (lv <= m_thresh);
         if (bus.r_thresh_wr) m_thresh = (int'(bus.r_thresh_in) > D) ? D : int'(bus.r_thresh_in);
         m_rbin = nr;
         m_level = lv;
      end
      @(posedge r_clk);
      #1;
      chk("addr",   32'(bus.r_addr),         32'(m_rbin % D));
      chk("gray",   32'(bus.r_gray),         32'(m_rbin ^ (m_rbin >> 1)));
      chk("level",  32'(bus.r_level),        32'(m_level));
      chk("empty",  32'(bus.r_empty),        32'(m_empty));
      chk("aempty", 32'(bus.r_almost_empty), 32'(m_ae));
      chk("uflow",  32'(bus.r_underflow),    32'(m_uf));
      chk("ptrerr", 32'(bus.r_ptr_err),      32'(m_pe));
   endtask

   initial begin
      bus.r_inc = 1'b0; bus.r_thresh_wr = 1'b0; bus.r_thresh_in = '0; bus.r_err_clr = 1'b0;
      setw(0);
      step();
      r_rst = 1'b0;

      for (int w = 1; w <= 5; w++) begin
         setw(w);
         step();
      end
      setw(8); step(); step();

      bus.r_inc = 1'b1;
      repeat (9) step();
      bus.r_inc = 1'b0;
      bus.r_err_clr = 1'b1; step(); bus.r_err_clr = 1'b0;

      setw(14); step();
      bus.r_inc = 1'b1; repeat (6) step(); bus.r_inc = 1'b0;
      setw(18); step();
      chk("wrap_level", 32'(bus.r_level), 32'd4);
      bus.r_inc = 1'b1; repeat (4) step(); bus.r_inc = 1'b0;
      chk("wrap_gray", 32'(bus.r_gray), 32'h1b);
      chk("wrap_empty", 32'(bus.r_empty), 32'd1);

      setw(21); step();
      bus.r_thresh_wr = 1'b1; bus.r_thresh_in = 5'd0; step();
      bus.r_thresh_wr = 1'b0; step();
      chk("thresh0_ae", 32'(bus.r_almost_empty), 32'd0);
      bus.r_inc = 1'b1; repeat (3) step(); bus.r_inc = 1'b0;
      bus.r_thresh_wr = 1'b1; bus.r_thresh_in = 5'd31; step();
      bus.r_thresh_wr = 1'b0;
      setw(31); step(); step();
      chk("thresh31_ae", 32'(bus.r_almost_empty), 32'd1);

      r_rst = 1'b1; step(); r_rst = 1'b0;
      setw(20); step();
      chk("ptrerr_set", 32'(bus.r_ptr_err), 32'd1);
      bus.r_err_clr = 1'b1; step();
      setw(0); step();
      bus.r_inc = 1'b1; step();
      chk("uflow_setwins", 32'(bus.r_underflow), 32'd1);
      bus.r_inc = 1'b0; bus.r_err_clr = 1'b0; step();

      setw(5); step();
      bus.r_inc = 1'b1; step(); step();
      r_rst = 1'b1; step();
      chk("midrst_level", 32'(bus.r_level), 32'd0);
      r_rst = 1'b0; bus.r_inc = 1'b0; step();

      repeat (400) begin
         bus.r_inc = 1'($urandom_range(0, 1));
         if (((m_w + M - m_rbin) % M) < D && $urandom_range(0, 2) != 0) setw(m_w + 1);
         bus.r_thresh_wr = ($urandom_range(0, 15) == 0);
         bus.r_thresh_in = 5'($urandom_range(0, 31));
         bus.r_err_clr = ($urandom_range(0, 15) == 0);
         r_rst = ($urandom_range(0, 63) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
